// File: rtl/serial_receiver.sv
// Serial word receiver: frames MSB-first marker-led words off a 1-bit line and queues them for a valid/ready consumer.
// Optional even-parity rejection of completed words when PARITY_CHECK_EN is defined.
module serial_receiver #(
  parameter int WORD_SIZE  = 23,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serial_in,
  output logic [WORD_SIZE-1:0] word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 busy,
  output logic                 overflow,
  output logic [12:0]          word_count,
  output logic [7:0]           parity_err_cnt
);

  localparam int CW = $clog2(WORD_SIZE-1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]                             state;
  logic [WORD_SIZE-2:0]                   shreg;
  logic [CW-1:0]                          bit_cnt;
  logic [FIFO_DEPTH-1:0][WORD_SIZE-1:0]   mem;
  logic [AW-1:0]                          rd_ptr, wr_ptr;
  logic [AW:0]                            occ;
  logic [WORD_SIZE-1:0]                   word_c;
  logic done, par_ok, full, pop, push;

  // Completed word includes the bit sampled on this edge, so it is pushed with zero extra latency.
  assign word_c = {shreg, serial_in};
  assign done   = (state == S_SHIFT) && (bit_cnt == '0);

`ifdef PARITY_CHECK_EN
  assign par_ok = ~^word_c;
`else
  assign par_ok = 1'b1;
`endif

  assign full       = (occ == (AW+1)'(FIFO_DEPTH));
  assign word_valid = (occ != '0);
  assign pop        = word_valid & word_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push       = done & par_ok & (~full | pop);
  assign busy       = (state == S_SHIFT);
  assign word_out   = word_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (serial_in) begin
          shreg   <= (WORD_SIZE-1)'(1);
          bit_cnt <= CW'(WORD_SIZE-2);
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          shreg <= word_c[WORD_SIZE-2:0];
          if (bit_cnt == '0) state <= S_IDLE;
          else               bit_cnt <= bit_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= word_c;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      if (done & par_ok & full & ~pop) overflow <= 1'b1;
      if (push) word_count <= word_count + 13'd1;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   parity_err_cnt <= '0;
    else if (done && !par_ok && parity_err_cnt != 8'hFF) parity_err_cnt <= parity_err_cnt + 8'd1;
  end
`else
  assign parity_err_cnt = '0;
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: word-level reference model checked every cycle, plus table and corner sequences.
module tb_serial_receiver;
  localparam int W = 23;
  localparam int D = 4;

  logic clk = 1'b0, rst_n = 1'b0, serial_in = 1'b0, word_ready = 1'b0;
  logic [W-1:0] word_out;
  logic word_valid, busy, overflow;
  logic [12:0] word_count;
  logic [7:0]  parity_err_cnt;

  logic s2 = 1'b0, r2 = 1'b1;
  logic [2:0] wo2;
  logic wv2, busy2, ovf2;
  logic [12:0] wc2;
  logic [7:0]  pe2;

  serial_receiver #(.WORD_SIZE(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .busy(busy), .overflow(overflow),
    .word_count(word_count), .parity_err_cnt(parity_err_cnt));

  serial_receiver #(.WORD_SIZE(3), .FIFO_DEPTH(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .serial_in(s2), .word_out(wo2),
    .word_valid(wv2), .word_ready(r2), .busy(busy2), .overflow(ovf2),
    .word_count(wc2), .parity_err_cnt(pe2));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Reference model: words as integers, FIFO as a queue.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_acc;
  bit m_inw, m_ovf;
  int m_n, m_cnt, m_perr;

  function automatic bit par_ok(input logic [W-1:0] w);
`ifdef PARITY_CHECK_EN
    return ($countones(w) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("word_valid", int'(word_valid), int'(m_q.size() > 0));
    chk("word_out", int'(word_out), (m_q.size() > 0) ? int'(m_q[0]) : 0);
    chk("busy", int'(busy), int'(m_inw));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("word_count", int'(word_count), m_cnt);
    chk("parity_err_cnt", int'(parity_err_cnt), m_perr);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_inw = 0; m_n = 0; m_acc = '0; m_ovf = 0; m_cnt = 0; m_perr = 0;
  endtask

  task automatic step(input bit s, input bit rdy);
    bit pop, done;
    serial_in = s; word_ready = rdy;
    pop = rdy && (m_q.size() > 0);
    done = 0;
    if (!m_inw) begin
      if (s) begin m_inw = 1; m_acc = 1; m_n = 1; end
    end else begin
      m_acc = {m_acc[W-2:0], s};
      m_n++;
      if (m_n == W) begin done = 1; m_inw = 0; end
    end
    if (pop) void'(m_q.pop_front());
    if (done) begin
      if (!par_ok(m_acc)) begin
        if (m_perr < 255) m_perr++;
      end else if (m_q.size() < D) begin
        m_q.push_back(m_acc);
        m_cnt = (m_cnt + 1) % 8192;
      end else m_ovf = 1;
    end
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit rdy);
    for (int i = W-1; i >= 0; i--) step(w[i], rdy);
  endtask

  task automatic do_reset();
    serial_in = 0; rst_n = 0;
    model_reset();
    #1; check_all();
    @(posedge clk); #1; check_all();
    rst_n = 1;
  endtask

  typedef struct {
    logic [W-1:0] w;
    bit           exp_acc;
    int           exp_cnt;
  } vec_t;

  vec_t vec[5];
  logic [W-1:0] t3w[6];
  logic [W-1:0] drain[4];
  logic [W-1:0] tmp;
  logic [2:0]   bits;
  int cum;

  initial begin
    vec[0].w = 23'h400000; vec[1].w = 23'h7FFFFF; vec[2].w = 23'h555555;
    vec[3].w = 23'h400001; vec[4].w = 23'h400003;
    cum = 0;
    for (int i = 0; i < 5; i++) begin
      vec[i].exp_acc = par_ok(vec[i].w);
      cum += int'(vec[i].exp_acc);
      vec[i].exp_cnt = cum;
    end
    t3w[0] = 23'h400001; t3w[1] = 23'h400002; t3w[2] = 23'h400004;
    t3w[3] = 23'h400008; t3w[4] = 23'h400010; t3w[5] = 23'h400020;
    drain[0] = 23'h400002; drain[1] = 23'h400004; drain[2] = 23'h400008; drain[3] = 23'h400020;

    // Reset state and single word
    do_reset();
    repeat (5) step(0, 0);
    tmp = 23'h400003;
    send_word(tmp, 0);
    chk("t1_valid", int'(word_valid), int'(par_ok(tmp)));
    chk("t1_out", int'(word_out), par_ok(tmp) ? int'(tmp) : 0);
    chk("t1_count", int'(word_count), int'(par_ok(tmp)));
    step(0, 0);
    chk("t1_busy", int'(busy), 0);

    // Back-to-back table, consumer always ready
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_word(vec[i].w, 1);
      chk("tbl_valid", int'(word_valid), int'(vec[i].exp_acc));
      chk("tbl_out", int'(word_out), vec[i].exp_acc ? int'(vec[i].w) : 0);
      chk("tbl_count", int'(word_count), vec[i].exp_cnt);
    end
    step(0, 1); step(0, 1);
    chk("tbl_ovf", int'(overflow), 0);
    chk("tbl_empty", int'(word_valid), 0);

    // Overflow with stalled consumer, then push at full coinciding with pop
    do_reset();
    for (int i = 0; i < 5; i++) send_word(t3w[i], 0);
    chk("t3_count4", int'(word_count), 4);
    chk("t3_ovf", int'(overflow), 1);
    chk("t3_head", int'(word_out), int'(t3w[0]));
    tmp = t3w[5];
    for (int i = W-1; i >= 1; i--) step(tmp[i], 0);
    step(tmp[0], 1);
    chk("t3_count5", int'(word_count), 5);
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", int'(word_out), int'(drain[i]));
      step(0, 1);
    end
    chk("t3_drained", int'(word_valid), 0);
    chk("t3_ovf_sticky", int'(overflow), 1);

    // Reset mid-word
    tmp = 23'h7ABCDE;
    for (int i = W-1; i >= W-10; i--) step(tmp[i], 0);
    do_reset();
    chk("t4_busy", int'(busy), 0);
    chk("t4_ovf", int'(overflow), 0);
    step(0, 0);
    tmp = 23'h400101;
    send_word(tmp, 0);
    chk("t4_out", int'(word_out), par_ok(tmp) ? int'(tmp) : 0);
    chk("t4_count", int'(word_count), int'(par_ok(tmp)));

    // Random stream with random consumer and occasional reset
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      else step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
    end

    // Counter wrap on a narrow instance: even-parity 3-bit words back-to-back
    serial_in = 0; word_ready = 0;
    do_reset();
    for (int k = 1; k <= 8193; k++) begin
      bits = k[0] ? 3'b101 : 3'b110;
      for (int b = 2; b >= 0; b--) begin
        s2 = bits[b];
        @(posedge clk); #1;
      end
      if (k == 8191) chk("wrap_8191", int'(wc2), 8191);
      if (k == 8192) chk("wrap_0", int'(wc2), 0);
      if (k == 8193) chk("wrap_1", int'(wc2), 1);
    end
    s2 = 0;
    chk("wrap_ovf", int'(ovf2), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
